// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common data bus (CDB) arbiter.
// Provides the default bus widths, the requester-ID encoding and a
// pointer-width helper used by the arbiter and its picker.
package cdb_arbiter_pkg;

    localparam int CDB_NUM_REQ   = 4;
    localparam int CDB_ROB_IDX_W = 4;
    localparam int CDB_DATA_W    = 32;

    // Functional-unit slot assignment on the requester vector.
    typedef enum logic [1:0] {
        REQ_ALU = 2'd0,
        REQ_LSB = 2'd1,
        REQ_BRU = 2'd2,
        REQ_MUL = 2'd3
    } req_id_e;

    // Width of an index into n requesters; never zero.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_priority_picker.sv
// One-hot picker: returns the first set request found when searching
// upward from ptr, wrapping modulo N. Purely combinational.
module rr_priority_picker
    import cdb_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = ptr_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic             found;
    logic [PTR_W-1:0] idx;
    int               sum;

    // Walk the N slots starting at ptr and grant the first requester seen.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        sum   = 0;
        for (int off = 0; off < N; off++) begin
            sum = int'(ptr) + off;
            if (sum >= N) sum = sum - N;
            idx = PTR_W'(sum);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one functional-unit result per cycle
// and broadcasts its ROB tag and data one cycle later.
// Build option: define CDB_ROUND_ROBIN_EN for rotating-pointer
// arbitration; otherwise fixed priority (lowest index wins).
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = CDB_NUM_REQ,
    parameter int ROB_IDX_W = CDB_ROB_IDX_W,
    parameter int DATA_W    = CDB_DATA_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ*ROB_IDX_W-1:0] req_rob_idx_i,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    output logic                         cdb_valid_o,
    output logic [ROB_IDX_W-1:0]         cdb_rob_idx_o,
    output logic [DATA_W-1:0]            cdb_data_o
);

    localparam int PTR_W = ptr_w(NUM_REQ);

    logic [NUM_REQ-1:0]   req_eff;
    logic [NUM_REQ-1:0]   gnt;
    logic [PTR_W-1:0]     ptr;
    logic                 xfer;
    logic [ROB_IDX_W-1:0] sel_tag;
    logic [DATA_W-1:0]    sel_data;

    // Reset and flush both squash every request before arbitration.
    assign req_eff     = (rst || flush_i) ? '0 : req_valid_i;
    assign req_ready_o = gnt;
    assign xfer        = |gnt;

    rr_priority_picker #(.N(NUM_REQ), .PTR_W(PTR_W)) u_picker (
        .req (req_eff),
        .ptr (ptr),
        .gnt (gnt)
    );

    // Select the granted slot's tag and data (grant is one-hot).
    always_comb begin
        sel_tag  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_tag  = sel_tag  | req_rob_idx_i[i*ROB_IDX_W +: ROB_IDX_W];
                sel_data = sel_data | req_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Broadcast register: tag/data hold their last value when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid_o   <= 1'b0;
            cdb_rob_idx_o <= '0;
            cdb_data_o    <= '0;
        end else begin
            cdb_valid_o <= xfer;
            if (xfer) begin
                cdb_rob_idx_o <= sel_tag;
                cdb_data_o    <= sel_data;
            end
        end
    end

`ifdef CDB_ROUND_ROBIN_EN
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] ptr_nxt;

    // Encode the grant and point just past it, wrapping at the top slot.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) gnt_idx = PTR_W'(i);
        end
        ptr_nxt = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end

    // Pointer only advances on a transfer.
    always_ff @(posedge clk) begin
        if (rst)       ptr <= '0;
        else if (xfer) ptr <= ptr_nxt;
    end
`else
    assign ptr = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter; follows the arbitration mode selected
// by CDB_ROUND_ROBIN_EN.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic [3:0]  req_valid_i;
    logic [15:0] req_rob_idx_i;
    logic [127:0] req_data_i;
    logic [3:0]  req_ready_o;
    logic        cdb_valid_o;
    logic [3:0]  cdb_rob_idx_o;
    logic [31:0] cdb_data_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  valid;
        logic        flush;
        logic [3:0]  ready;
        logic        cv;
        logic [3:0]  tag;
        logic [31:0] data;
    } vec_t;

    vec_t tbl[$];

    cdb_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .req_valid_i   (req_valid_i),
        .req_rob_idx_i (req_rob_idx_i),
        .req_data_i    (req_data_i),
        .req_ready_o   (req_ready_o),
        .cdb_valid_o   (cdb_valid_o),
        .cdb_rob_idx_o (cdb_rob_idx_o),
        .cdb_data_o    (cdb_data_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] v, input logic f, input logic [3:0] r,
                                input logic cv, input logic [3:0] t, input logic [31:0] d);
        vec_t x;
        x.valid = v; x.flush = f; x.ready = r; x.cv = cv; x.tag = t; x.data = d;
        return x;
    endfunction

    // Slot i: tag i+8, data C0DE000i.
    task automatic default_slots();
        for (int i = 0; i < 4; i++) begin
            req_rob_idx_i[i*4 +: 4]  = 4'(i + 8);
            req_data_i[i*32 +: 32]   = 32'hC0DE_0000 | 32'(i);
        end
    endtask

    // Drive one cycle: check ready before the edge, broadcast after it.
    task automatic step(input string name, input logic [3:0] v, input logic f,
                        input logic [3:0] r, input logic cv, input logic [3:0] t,
                        input logic [31:0] d);
        @(negedge clk);
        req_valid_i = v;
        flush_i     = f;
        #1;
        chk({name, ".ready"}, 32'(req_ready_o), 32'(r));
        @(posedge clk);
        #1;
        chk({name, ".cv"},   32'(cdb_valid_o), 32'(cv));
        chk({name, ".tag"},  32'(cdb_rob_idx_o), 32'(t));
        chk({name, ".data"}, cdb_data_o, d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid_i = 4'b1111;
        flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", 32'(req_ready_o), 32'h0);
        chk("rst.cv",    32'(cdb_valid_o), 32'h0);
        chk("rst.tag",   32'(cdb_rob_idx_o), 32'h0);
        chk("rst.data",  cdb_data_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        req_valid_i = '0;
    endtask

    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        req_valid_i = '0;
        default_slots();

`ifdef CDB_ROUND_ROBIN_EN
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(4'b1111, 0, 4'b0001 << (k % 4), 1, 4'(8 + k % 4), 32'hC0DE_0000 | 32'(k % 4)));
        tbl.push_back(mk(4'b1010, 0, 4'b0010, 1, 4'd9,  32'hC0DE_0001));
        tbl.push_back(mk(4'b1010, 0, 4'b1000, 1, 4'd11, 32'hC0DE_0003));
        tbl.push_back(mk(4'b0000, 0, 4'b0000, 0, 4'd11, 32'hC0DE_0003));
        tbl.push_back(mk(4'b0110, 1, 4'b0000, 0, 4'd11, 32'hC0DE_0003));
        tbl.push_back(mk(4'b0110, 0, 4'b0010, 1, 4'd9,  32'hC0DE_0001));
        tbl.push_back(mk(4'b0011, 0, 4'b0001, 1, 4'd8,  32'hC0DE_0000));
`else
        tbl.push_back(mk(4'b0001, 0, 4'b0001, 1, 4'd8,  32'hC0DE_0000));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(4'b1010, 0, 4'b0010, 1, 4'd9, 32'hC0DE_0001));
        tbl.push_back(mk(4'b1000, 0, 4'b1000, 1, 4'd11, 32'hC0DE_0003));
        tbl.push_back(mk(4'b0000, 0, 4'b0000, 0, 4'd11, 32'hC0DE_0003));
        tbl.push_back(mk(4'b0001, 1, 4'b0000, 0, 4'd11, 32'hC0DE_0003));
        tbl.push_back(mk(4'b0001, 0, 4'b0001, 1, 4'd8,  32'hC0DE_0000));
        tbl.push_back(mk(4'b1111, 0, 4'b0001, 1, 4'd8,  32'hC0DE_0000));
        tbl.push_back(mk(4'b1100, 0, 4'b0100, 1, 4'd10, 32'hC0DE_0002));
`endif

        do_reset();
        for (int k = 0; k < tbl.size(); k++)
            step($sformatf("vec%0d", k), tbl[k].valid, tbl[k].flush, tbl[k].ready,
                 tbl[k].cv, tbl[k].tag, tbl[k].data);

        // Single requester on slot 2.
        do_reset();
        req_rob_idx_i[8 +: 4]  = 4'd5;
        req_data_i[64 +: 32]   = 32'hDEAD_BEEF;
        step("single", 4'b0100, 0, 4'b0100, 1, 4'd5, 32'hDEAD_BEEF);

        // Idle after a broadcast of tag 7: tag/data hold, pointer holds.
        req_rob_idx_i[4 +: 4]  = 4'd7;
        req_data_i[32 +: 32]   = 32'h0000_0077;
        step("bcast7", 4'b0010, 0, 4'b0010, 1, 4'd7, 32'h0000_0077);
        for (int k = 0; k < 3; k++)
            step($sformatf("idle%0d", k), 4'b0000, 0, 4'b0000, 0, 4'd7, 32'h0000_0077);
`ifdef CDB_ROUND_ROBIN_EN
        step("after_idle", 4'b1111, 0, 4'b0100, 1, 4'd5, 32'hDEAD_BEEF);
`else
        step("after_idle", 4'b1111, 0, 4'b0001, 1, 4'd8, 32'hC0DE_0000);
`endif

        // Reset mid-stream with a broadcast pending (pointer at 2 under RR).
        step("pre_rst", 4'b0010, 0, 4'b0010, 1, 4'd7, 32'h0000_0077);
        @(negedge clk);
        rst = 1'b1;
        req_valid_i = 4'b1111;
        #1;
        chk("midrst.ready", 32'(req_ready_o), 32'h0);
        @(posedge clk);
        #1;
        chk("midrst.cv",   32'(cdb_valid_o), 32'h0);
        chk("midrst.tag",  32'(cdb_rob_idx_o), 32'h0);
        chk("midrst.data", cdb_data_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 4'b1111, 0, 4'b0001, 1, 4'd8, 32'hC0DE_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
